// File: rtl/tcp_tx_framer.sv
// tcp_tx_framer: frames an upstream byte stream into SiTCP TX writes.
// Optional checksum trailer byte: define TCP_TX_FRAMER_CHECKSUM_EN.
module tcp_tx_framer #(
   parameter int         PAYLOAD_LEN = 16,
   parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
   input  logic        CLK_200M,
   input  logic        SYS_RSTn,
   input  logic        TCP_OPEN_ACK,
   input  logic [7:0]  IN_DATA,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic        TCP_TX_FULL,
   output logic        TCP_TX_WR,
   output logic [7:0]  TCP_TX_DATA,
   output logic [15:0] FRAME_CNT,
   output logic        BUSY
);

   localparam logic [7:0] LAST = 8'(PAYLOAD_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_SEQH,
      S_SEQL,
      S_PAYLOAD
`ifdef TCP_TX_FRAMER_CHECKSUM_EN
      , S_CSUM
`endif
   } state_t;

   state_t      r_state;
   state_t      w_nxt;
   logic        r_wr;
   logic [7:0]  r_data;
   logic [15:0] r_seq;
   logic [15:0] r_fcnt;
   logic [7:0]  r_cnt;
   logic        r_ack_d;
   logic        w_go;
   logic        w_take;
   logic        w_rise;
   logic        w_wr;
   logic        w_done;
   logic [7:0]  w_data;
`ifdef TCP_TX_FRAMER_CHECKSUM_EN
   logic [7:0]  r_csum;
   logic        w_clr;
   logic        w_acc;
`endif

   // a byte may only leave when the link is up and SiTCP has room
   assign w_go   = TCP_OPEN_ACK & ~TCP_TX_FULL;
   assign w_take = (r_state == S_PAYLOAD) & w_go & IN_VALID;
   assign w_rise = TCP_OPEN_ACK & ~r_ack_d;

   assign IN_READY    = SYS_RSTn & (r_state == S_PAYLOAD) & w_go;
   assign BUSY        = (r_state != S_IDLE);
   assign TCP_TX_WR   = r_wr;
   assign TCP_TX_DATA = r_data;
   assign FRAME_CNT   = r_fcnt;

   always_comb begin
      w_nxt  = r_state;
      w_wr   = 1'b0;
      w_data = 8'h00;
      w_done = 1'b0;
`ifdef TCP_TX_FRAMER_CHECKSUM_EN
      w_clr  = 1'b0;
      w_acc  = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (TCP_OPEN_ACK && IN_VALID) w_nxt = S_HDR;
         end
         S_HDR: begin
            if (w_go) begin
               w_wr   = 1'b1;
               w_data = HDR_BYTE;
               w_nxt  = S_SEQH;
`ifdef TCP_TX_FRAMER_CHECKSUM_EN
               w_clr  = 1'b1;
`endif
            end
         end
         S_SEQH: begin
            if (w_go) begin
               w_wr   = 1'b1;
               w_data = r_seq[15:8];
               w_nxt  = S_SEQL;
`ifdef TCP_TX_FRAMER_CHECKSUM_EN
               w_acc  = 1'b1;
`endif
            end
         end
         S_SEQL: begin
            if (w_go) begin
               w_wr   = 1'b1;
               w_data = r_seq[7:0];
               w_nxt  = S_PAYLOAD;
`ifdef TCP_TX_FRAMER_CHECKSUM_EN
               w_acc  = 1'b1;
`endif
            end
         end
         S_PAYLOAD: begin
            if (w_take) begin
               w_wr   = 1'b1;
               w_data = IN_DATA;
`ifdef TCP_TX_FRAMER_CHECKSUM_EN
               w_acc  = 1'b1;
               if (r_cnt == LAST) w_nxt = S_CSUM;
`else
               if (r_cnt == LAST) begin
                  w_nxt  = S_IDLE;
                  w_done = 1'b1;
               end
`endif
            end
         end
`ifdef TCP_TX_FRAMER_CHECKSUM_EN
         S_CSUM: begin
            if (w_go) begin
               w_wr   = 1'b1;
               w_data = r_csum;
               w_nxt  = S_IDLE;
               w_done = 1'b1;
            end
         end
`endif
         default: w_nxt = S_IDLE;
      endcase
      // link loss abandons the partial frame
      if (r_state != S_IDLE && !TCP_OPEN_ACK) w_nxt = S_IDLE;
   end

   always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
      if (!SYS_RSTn) r_state <= S_IDLE;
      else           r_state <= w_nxt;
   end

   always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
      if (!SYS_RSTn) begin
         r_wr    <= 1'b0;
         r_data  <= 8'h00;
         r_seq   <= 16'h0000;
         r_fcnt  <= 16'h0000;
         r_cnt   <= 8'h00;
         r_ack_d <= 1'b0;
      end else begin
         r_wr    <= w_wr;
         r_ack_d <= TCP_OPEN_ACK;
         if (w_wr) r_data <= w_data;
         if (w_rise)      r_seq <= 16'h0000;
         else if (w_done) r_seq <= r_seq + 16'd1;
         if (w_done) r_fcnt <= r_fcnt + 16'd1;
         if (r_state == S_IDLE) r_cnt <= 8'h00;
         else if (w_take)       r_cnt <= r_cnt + 8'd1;
      end
   end

`ifdef TCP_TX_FRAMER_CHECKSUM_EN
   always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
      if (!SYS_RSTn)  r_csum <= 8'h00;
      else if (w_clr) r_csum <= 8'h00;
      else if (w_acc) r_csum <= r_csum + w_data;
   end
`endif

endmodule

// File: tb/tb_tcp_tx_framer.sv
// tb_tcp_tx_framer: random and directed frames against a queue-based
// frame model of tcp_tx_framer (PAYLOAD_LEN=4).
module tb_tcp_tx_framer;

   localparam int PL = 4;
`ifdef TCP_TX_FRAMER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam int FLEN = PL + 3 + CS;

   logic        CLK_200M = 1'b0;
   logic        SYS_RSTn = 1'b0;
   logic        TCP_OPEN_ACK = 1'b0;
   logic [7:0]  IN_DATA = 8'h00;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic        TCP_TX_FULL = 1'b0;
   logic        TCP_TX_WR;
   logic [7:0]  TCP_TX_DATA;
   logic [15:0] FRAME_CNT;
   logic        BUSY;

   tcp_tx_framer #(.PAYLOAD_LEN(PL), .HDR_BYTE(8'hA5)) dut (
      .CLK_200M     (CLK_200M),
      .SYS_RSTn     (SYS_RSTn),
      .TCP_OPEN_ACK (TCP_OPEN_ACK),
      .IN_DATA      (IN_DATA),
      .IN_VALID     (IN_VALID),
      .IN_READY     (IN_READY),
      .TCP_TX_FULL  (TCP_TX_FULL),
      .TCP_TX_WR    (TCP_TX_WR),
      .TCP_TX_DATA  (TCP_TX_DATA),
      .FRAME_CNT    (FRAME_CNT),
      .BUSY         (BUSY)
   );

   always #5 CLK_200M = ~CLK_200M;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0]  rxq[$];
   int          rxt[$];
   logic [7:0]  expq[$];
   int          cyc = 0;
   logic [15:0] m_seq = 16'h0000;
   logic [15:0] m_fcnt = 16'h0000;

   // capture every TX write with its cycle number
   always @(posedge CLK_200M) begin : mon
      logic f;
      f = TCP_TX_FULL;
      cyc++;
      #1;
      if (TCP_TX_WR === 1'b1) begin
         chk("wr_after_full", 32'(f), 0);
         rxq.push_back(TCP_TX_DATA);
         rxt.push_back(cyc);
      end
   end

   task automatic make_exp(input logic [15:0] s, input logic [7:0] p[PL]);
      int sum;
      expq.delete();
      expq.push_back(8'hA5);
      expq.push_back(s[15:8]);
      expq.push_back(s[7:0]);
      sum = s[15:8] + s[7:0];
      for (int k = 0; k < PL; k++) begin
         expq.push_back(p[k]);
         sum += p[k];
      end
      if (CS == 1) expq.push_back(8'(sum % 256));
   endtask

   task automatic send(input logic [7:0] p[PL], input int full_pct,
                       input bit stall3);
      int i = 0;
      int guard = 0;
      bit stalled = 0;
      while (i < PL && guard < 200) begin
         @(negedge CLK_200M);
         guard++;
         IN_VALID = 1'b1;
         IN_DATA  = p[i];
         if (stall3 && i == 1 && !stalled) begin
            stalled = 1;
            repeat (3) begin
               TCP_TX_FULL = 1'b1;
               #1 chk("rdy_stall", 32'(IN_READY), 0);
               @(negedge CLK_200M);
            end
         end
         TCP_TX_FULL = ($urandom_range(99) < full_pct);
         #1;
         if (TCP_TX_FULL) chk("rdy_full", 32'(IN_READY), 0);
         if (IN_READY) i++;
      end
      chk("send_done", i, PL);
      @(negedge CLK_200M);
      IN_VALID    = 1'b0;
      TCP_TX_FULL = 1'b0;
   endtask

   task automatic check_frame(input string tag, input int span);
      int g = 0;
      while (rxq.size() < expq.size() && g < 40) begin
         @(negedge CLK_200M);
         g++;
      end
      repeat (3) @(negedge CLK_200M);
      chk({tag, "_len"}, rxq.size(), expq.size());
      for (int k = 0; k < expq.size() && k < rxq.size(); k++)
         chk($sformatf("%s_b%0d", tag, k), 32'(rxq[k]), 32'(expq[k]));
      if (span > 0 && rxt.size() > 0)
         chk({tag, "_span"}, rxt[rxt.size()-1] - rxt[0] + 1, span);
      m_seq  = m_seq + 16'd1;
      m_fcnt = m_fcnt + 16'd1;
      chk({tag, "_fcnt"}, 32'(FRAME_CNT), 32'(m_fcnt));
   endtask

   task automatic frame(input string tag, input logic [7:0] p[PL],
                        input int full_pct, input bit stall3,
                        input int span);
      rxq.delete();
      rxt.delete();
      make_exp(m_seq, p);
      send(p, full_pct, stall3);
      check_frame(tag, span);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] p[PL];
      logic [7:0] q[PL];
      int acc;
      int g;

      IN_VALID = 1'b1;
      TCP_OPEN_ACK = 1'b1;
      #2;
      chk("rst_wr", 32'(TCP_TX_WR), 0);
      chk("rst_data", 32'(TCP_TX_DATA), 0);
      chk("rst_fcnt", 32'(FRAME_CNT), 0);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_ready", 32'(IN_READY), 0);
      IN_VALID = 1'b0;
      TCP_OPEN_ACK = 1'b0;
      repeat (2) @(negedge CLK_200M);
      SYS_RSTn = 1'b1;
      @(negedge CLK_200M);
      TCP_OPEN_ACK = 1'b1;

      p = '{8'h01, 8'h02, 8'h03, 8'h04};
      frame("basic", p, 0, 1'b0, FLEN);
      frame("stall", p, 0, 1'b1, FLEN + 3);

      for (int n = 0; n < 20; n++) begin
         for (int k = 0; k < PL; k++) q[k] = 8'($urandom);
         frame($sformatf("rnd%0d", n), q, 30, 1'b0, 0);
      end

      // link drop after payload byte 02
      rxq.delete();
      rxt.delete();
      acc = 0;
      g = 0;
      while (acc < 2 && g < 100) begin
         @(negedge CLK_200M);
         g++;
         IN_VALID = 1'b1;
         IN_DATA  = p[acc];
         TCP_TX_FULL = 1'b0;
         #1;
         if (IN_READY) acc++;
      end
      chk("abort_acc", acc, 2);
      @(negedge CLK_200M);
      TCP_OPEN_ACK = 1'b0;
      IN_VALID = 1'b0;
      @(posedge CLK_200M);
      #1 chk("abort_busy", 32'(BUSY), 0);
      repeat (4) @(negedge CLK_200M);
      chk("abort_writes", rxq.size(), 5);
      chk("abort_seqh", 32'(rxq[1]), 32'(m_seq[15:8]));
      chk("abort_seql", 32'(rxq[2]), 32'(m_seq[7:0]));
      chk("abort_fcnt", 32'(FRAME_CNT), 32'(m_fcnt));
      TCP_OPEN_ACK = 1'b1;
      m_seq = 16'h0000;
      frame("reopen", p, 0, 1'b0, FLEN);

      // sequence wrap
      @(negedge CLK_200M);
      force dut.r_seq = 16'hFFFF;
      @(negedge CLK_200M);
      release dut.r_seq;
      m_seq = 16'hFFFF;
      frame("wrap", p, 0, 1'b0, FLEN);
      chk("wrap_model_seq", 32'(m_seq), 0);
      frame("post_wrap", p, 20, 1'b0, 0);

      // asynchronous reset in the middle of a payload
      acc = 0;
      g = 0;
      while (acc < 1 && g < 100) begin
         @(negedge CLK_200M);
         g++;
         IN_VALID = 1'b1;
         IN_DATA  = 8'h55;
         #1;
         if (IN_READY) acc++;
      end
      chk("mid_acc", acc, 1);
      @(negedge CLK_200M);
      #1 SYS_RSTn = 1'b0;
      #1;
      chk("mid_rst_wr", 32'(TCP_TX_WR), 0);
      chk("mid_rst_data", 32'(TCP_TX_DATA), 0);
      chk("mid_rst_fcnt", 32'(FRAME_CNT), 0);
      chk("mid_rst_busy", 32'(BUSY), 0);
      chk("mid_rst_ready", 32'(IN_READY), 0);
      IN_VALID = 1'b0;
      @(negedge CLK_200M);
      SYS_RSTn = 1'b1;
      m_seq  = 16'h0000;
      m_fcnt = 16'h0000;
      rxq.delete();
      repeat (5) @(negedge CLK_200M);
      chk("post_rst_idle", rxq.size(), 0);
      p = '{8'h10, 8'h20, 8'h30, 8'h40};
      frame("post_rst", p, 0, 1'b0, FLEN);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
